// File: rtl/sw_word_entry_pkg.sv
// Shared types and constants for the hex-nibble word entry block.
package sw_entry_pkg;

  localparam int NIBBLES_PER_WORD = 8;
  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 32;
  localparam int COUNT_W          = 4;

  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } entry_state_t;

  // Nibble count saturates once a full word has been keyed in.
  function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] count);
    if (count >= COUNT_W'(NIBBLES_PER_WORD)) begin
      return COUNT_W'(NIBBLES_PER_WORD);
    end
    return count + 1'b1;
  endfunction

endpackage

// File: rtl/sw_word_entry_if.sv
// Committed-word handshake towards the system data-in port.
interface sw_word_entry_if;

  logic [sw_entry_pkg::WORD_W-1:0] data_word;
  logic                            data_valid;
  logic                            data_ack;

  modport master (
    output data_word,
    output data_valid,
    input  data_ack
  );

  modport slave (
    input  data_word,
    input  data_valid,
    output data_ack
  );

endinterface

// File: rtl/sw_word_entry_key_debounce.sv
// Push-button conditioner: synchronizer, stability counter, one-cycle press pulse
// on a debounced 1->0 transition of the active-low input.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   prev_reg;
  logic                   level_reg;
  logic                   pulse_reg;
  logic                   sync_level;

  assign sync_level  = sync_reg[SYNC_STAGES-1];
  assign press_pulse = pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '1;
      cnt_reg   <= '0;
      prev_reg  <= 1'b1;
      level_reg <= 1'b1;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg[0] <= key_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg  <= sync_level;
      pulse_reg <= 1'b0;
      if (sync_level != prev_reg) begin
        cnt_reg <= '0;
      end else begin
        if (cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        // Accept the level only once it has been stable long enough; the
        // equality guard keeps a fresh edge from riding a saturated counter.
        if (cnt_reg == CNT_MAX) begin
          level_reg <= sync_level;
          pulse_reg <= level_reg & ~sync_level;
        end
      end
    end
  end

endmodule

// File: rtl/sw_word_entry.sv
// Keys a 32-bit word in one hex nibble at a time and hands it off with valid/ack.
module sw_word_entry
  import sw_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NIBBLE_W-1:0] sw_nibble,
  input  logic                key_enter_n,
  input  logic                key_commit_n,
  sw_word_entry_if.master     data_bus,
  output logic [WORD_W-1:0]   entry_word,
  output logic [COUNT_W-1:0]  nibble_count,
  output logic                busy
);

  logic [1:0] keys_n;
  logic [1:0] pulses;
  logic       enter_pulse;
  logic       commit_pulse;

  assign keys_n       = {key_commit_n, key_enter_n};
  assign enter_pulse  = pulses[0];
  assign commit_pulse = pulses[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
      ) u_key_debounce (
        .clk        (clk),
        .rst        (rst),
        .key_n      (keys_n[gi]),
        .press_pulse(pulses[gi])
      );
    end
  endgenerate

  entry_state_t state_reg;
  entry_state_t state_next;

  logic [WORD_W-1:0]  entry_word_reg;
  logic [WORD_W-1:0]  data_word_reg;
  logic [COUNT_W-1:0] nibble_count_reg;
  logic               data_valid_reg;
  logic [WORD_W-1:0]  shifted_word;
  logic               do_shift;
  logic               do_commit;
  logic               do_release;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ENTRY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ENTRY:   if (commit_pulse)      state_next = HOLD;
      HOLD:    if (data_bus.data_ack) state_next = ENTRY;
      default: state_next = ENTRY;
    endcase
  end

  always_comb begin
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    do_release = 1'b0;
    case (state_reg)
      ENTRY: begin
        do_shift  = enter_pulse;
        do_commit = commit_pulse;
      end
      HOLD:    do_release = data_bus.data_ack;
      default: ;
    endcase
  end

  assign shifted_word = {entry_word_reg[WORD_W-NIBBLE_W-1:0], sw_nibble};

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_word_reg   <= '0;
      data_word_reg    <= '0;
      nibble_count_reg <= '0;
      data_valid_reg   <= 1'b0;
    end else begin
      // A same-cycle enter is folded into the committed word before it is cleared.
      if (do_commit) begin
        data_word_reg    <= do_shift ? shifted_word : entry_word_reg;
        data_valid_reg   <= 1'b1;
        entry_word_reg   <= '0;
        nibble_count_reg <= '0;
      end else if (do_shift) begin
        entry_word_reg   <= shifted_word;
        nibble_count_reg <= sat_inc_count(nibble_count_reg);
      end
      if (do_release) begin
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign data_bus.data_word  = data_word_reg;
  assign data_bus.data_valid = data_valid_reg;
  assign entry_word          = entry_word_reg;
  assign nibble_count        = nibble_count_reg;
  assign busy                = (state_reg == HOLD);

endmodule
